// File: rtl/fnd_scan_controller.sv
// Time-multiplexed scan controller for a 4-digit common-anode FND.
// Each digit is lit for SCAN_DIV clocks, separated by GUARD_CYC dark clocks.
module fnd_scan_controller #(
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD_CYC    = 2000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_digits,
  input  logic [3:0]  i_blank_mask,
  input  logic [3:0]  i_blink_mask,
  input  logic        i_lz_en,
  output logic [3:0]  o_value,
  output logic        o_on_off,
  output logic [3:0]  o_digit_sel,
  output logic        o_frame_tick
);

  localparam int MAX_CYC = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam int FRM_W   = $clog2(BLINK_FRAMES) + 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(BLINK_FRAMES - 1);

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       r_idx, idx_nxt;
  logic [CNT_W-1:0] r_cnt, cnt_nxt;
  logic [FRM_W-1:0] frame_cnt, frame_nxt;
  logic             blink_phase, phase_nxt;
  logic [3:0]       value_nxt;
  logic             on_off_nxt;
  logic [3:0]       sel_nxt;
  logic             tick_nxt;

  logic [3:0]       code_zero;
  logic [3:0]       cur_code;
  logic             lz_blank;
  logic             blank_now;

  // A digit is LZ-suppressed only when it and every more significant digit are 0.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      code_zero[n] = (i_digits[4*n +: 4] == 4'd0);
    end
    cur_code = i_digits[{r_idx, 2'b00} +: 4];
    case (r_idx)
      2'd1:    lz_blank = &code_zero[3:1];
      2'd2:    lz_blank = &code_zero[3:2];
      2'd3:    lz_blank = code_zero[3];
      default: lz_blank = 1'b0;
    endcase
    blank_now = i_blank_mask[r_idx]
              | (i_blink_mask[r_idx] & blink_phase)
              | (i_lz_en & lz_blank);
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = r_cnt + CNT_W'(1);
    idx_nxt    = r_idx;
    frame_nxt  = frame_cnt;
    phase_nxt  = blink_phase;
    value_nxt  = o_value;
    on_off_nxt = o_on_off;
    sel_nxt    = o_digit_sel;
    tick_nxt   = 1'b0;

    case (state)
      ST_GUARD: begin
        sel_nxt    = 4'b1111;
        on_off_nxt = 1'b1;
        if (r_cnt == GUARD_LAST) begin
          state_nxt  = ST_SHOW;
          cnt_nxt    = '0;
          value_nxt  = cur_code;
          on_off_nxt = blank_now;
          sel_nxt    = ~(4'b0001 << r_idx);
        end
      end
      ST_SHOW: begin
        if (r_cnt == SHOW_LAST) begin
          state_nxt  = ST_GUARD;
          cnt_nxt    = '0;
          idx_nxt    = r_idx + 2'd1;
          sel_nxt    = 4'b1111;
          on_off_nxt = 1'b1;
          // Leaving digit3 closes a frame; the blink phase advances here.
          if (r_idx == 2'd3) begin
            tick_nxt = 1'b1;
            if (frame_cnt == FRAME_LAST) begin
              frame_nxt = '0;
              phase_nxt = ~blink_phase;
            end else begin
              frame_nxt = frame_cnt + FRM_W'(1);
            end
          end
        end
      end
      default: begin
        state_nxt = ST_GUARD;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state        <= ST_GUARD;
      r_idx        <= 2'd0;
      r_cnt        <= '0;
      frame_cnt    <= '0;
      blink_phase  <= 1'b0;
      o_value      <= 4'hf;
      o_on_off     <= 1'b1;
      o_digit_sel  <= 4'b1111;
      o_frame_tick <= 1'b0;
    end else begin
      state        <= state_nxt;
      r_idx        <= idx_nxt;
      r_cnt        <= cnt_nxt;
      frame_cnt    <= frame_nxt;
      blink_phase  <= phase_nxt;
      o_value      <= value_nxt;
      o_on_off     <= on_off_nxt;
      o_digit_sel  <= sel_nxt;
      o_frame_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller: table-driven vectors with a
// per-cycle scoreboard queue, plus hand sequences for mid-SHOW input and reset.
module tb_fnd_scan_controller;

  localparam int SCAN_DIV     = 4;
  localparam int GUARD_CYC    = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int DIGIT_PER    = SCAN_DIV + GUARD_CYC;
  localparam int FRAME_PER    = 4 * DIGIT_PER;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] digits;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic        lz_en;
  logic [3:0]  value;
  logic        on_off;
  logic [3:0]  digit_sel;
  logic        frame_tick;

  always #5 clk = ~clk;

  fnd_scan_controller #(
    .SCAN_DIV    (SCAN_DIV),
    .GUARD_CYC   (GUARD_CYC),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_digits    (digits),
    .i_blank_mask(blank_mask),
    .i_blink_mask(blink_mask),
    .i_lz_en     (lz_en),
    .o_value     (value),
    .o_on_off    (on_off),
    .o_digit_sel (digit_sel),
    .o_frame_tick(frame_tick)
  );

  typedef struct {
    logic [15:0] digits;
    logic [15:0] digits_b;
    int          switch_k;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic        lz;
    logic [15:0] exp_val;
    logic [3:0]  off0;
    logic [3:0]  off1;
    int          cycles;
  } vec_t;

  typedef struct {
    int         k;
    logic [3:0] sel;
    logic       tick;
    logic       show;
    logic [3:0] value;
    logic       off;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_id = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int k,
                              input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL vec%0d %s cycle=%0d got=%h expected=%h",
               cur_id, name, k, got, exp);
    end
  endtask

  // Cycle k counts edges since reset release; digit0 SHOW begins at k=GUARD_CYC.
  function automatic exp_t expect_at(input vec_t v, input int k);
    exp_t e;
    int   j, pos, d, q, phase;
    e.k = k; e.sel = 4'b1111; e.tick = 1'b0; e.show = 1'b0;
    e.value = 4'h0; e.off = 1'b1;
    j = k - GUARD_CYC;
    if (j >= 0) begin
      pos   = j % FRAME_PER;
      d     = pos / DIGIT_PER;
      q     = pos % DIGIT_PER;
      phase = (j / FRAME_PER / BLINK_FRAMES) % 2;
      e.tick = (pos == FRAME_PER - GUARD_CYC);
      if (q < SCAN_DIV) begin
        e.show  = 1'b1;
        e.sel   = ~(4'b0001 << d);
        e.value = v.exp_val[4*d +: 4];
        e.off   = (phase != 0) ? v.off1[d] : v.off0[d];
      end
    end
    return e;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    check_output("rst_sel",    0, digit_sel, 4'b1111);
    check_output("rst_value",  0, value, 4'hf);
    check_output("rst_on_off", 0, {3'b000, on_off}, 4'h1);
    check_output("rst_tick",   0, {3'b000, frame_tick}, 4'h0);
    reset_n = 1'b1;
  endtask

  task automatic apply_stimulus(input vec_t v, input int first_k, input int last_k);
    exp_t e;
    for (int k = first_k; k <= last_k; k++) begin
      digits     = (v.switch_k != 0 && k >= v.switch_k) ? v.digits_b : v.digits;
      blank_mask = v.blank;
      blink_mask = v.blink;
      lz_en      = v.lz;
      sb_q.push_back(expect_at(v, k));
      step();
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL vec%0d scoreboard_empty cycle=%0d got=0 expected=1", cur_id, k);
      end else begin
        e = sb_q.pop_front();
        check_output("sel",  e.k, digit_sel, e.sel);
        check_output("tick", e.k, {3'b000, frame_tick}, {3'b000, e.tick});
        check_output("on_off", e.k, {3'b000, on_off}, {3'b000, e.off});
        if (e.show) check_output("value", e.k, value, e.value);
      end
    end
  endtask

  function automatic vec_t mk(input logic [15:0] d, input logic [3:0] blank,
                              input logic [3:0] blink, input logic lz,
                              input logic [15:0] exp_val, input logic [3:0] off0,
                              input logic [3:0] off1, input int frames);
    vec_t v;
    v.digits = d; v.digits_b = d; v.switch_k = 0;
    v.blank = blank; v.blink = blink; v.lz = lz;
    v.exp_val = exp_val; v.off0 = off0; v.off1 = off1;
    v.cycles = GUARD_CYC - 1 + frames * FRAME_PER;
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    vec_t vecs[7];
    vec_t v;

    reset_n = 1'b0; digits = 16'h0000; blank_mask = 4'h0;
    blink_mask = 4'h0; lz_en = 1'b0;

    vecs[0] = mk(16'h1234, 4'h0, 4'h0, 1'b0, 16'h1234, 4'b0000, 4'b0000, 1);
    vecs[1] = mk(16'h0050, 4'h0, 4'h0, 1'b1, 16'h0050, 4'b1100, 4'b1100, 1);
    vecs[2] = mk(16'h0000, 4'h0, 4'h0, 1'b1, 16'h0000, 4'b1110, 4'b1110, 1);
    vecs[3] = mk(16'h1234, 4'h0, 4'b0011, 1'b0, 16'h1234, 4'b0000, 4'b0011, 5);
    vecs[4] = mk(16'hA9B0, 4'b1000, 4'h0, 1'b0, 16'hA9B0, 4'b1000, 4'b1000, 1);
    vecs[5] = mk(16'h0A00, 4'h0, 4'h0, 1'b1, 16'h0A00, 4'b1000, 4'b1000, 1);
    vecs[6] = mk(16'h0007, 4'b0001, 4'h0, 1'b1, 16'h0007, 4'b1111, 4'b1111, 1);

    step();
    for (int i = 0; i < 7; i++) begin
      cur_id = i;
      do_reset();
      apply_stimulus(vecs[i], 1, vecs[i].cycles);
    end

    // Inputs change two clocks into digit0 SHOW; the captured code must hold.
    cur_id = 7;
    v = mk(16'h1234, 4'h0, 4'h0, 1'b0, 16'h5674, 4'b0000, 4'b0000, 1);
    v.digits_b = 16'h5678;
    v.switch_k = GUARD_CYC + 3;
    do_reset();
    apply_stimulus(v, 1, v.cycles);

    // Reset during digit2 SHOW of frame 2 while the blink phase is 1.
    cur_id = 8;
    v = mk(16'h1234, 4'h0, 4'b0011, 1'b0, 16'h1234, 4'b0000, 4'b0011, 1);
    do_reset();
    apply_stimulus(v, 1, GUARD_CYC + 2 * FRAME_PER + 2 * DIGIT_PER + 1);
    do_reset();
    apply_stimulus(v, 1, v.cycles);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
